// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller and its BCD digit cells.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int unsigned presc_width(input int unsigned p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 decade: counts 0..9 when enabled, synchronous clear wins over enable.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] q,
  output logic       at_max
);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (clear)  r_q <= '0;
    else if (en)     r_q <= bcd_inc(r_q);
  end

  assign q      = r_q;
  assign at_max = (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: command FSM, tick prescaler, BCD enable cascade, lap freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_valid,
  output logic                    overflow
);

  localparam int unsigned     PW         = presc_width(PRESCALE);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

  state_t                  r_state, w_state_next;
  logic [PW-1:0]           r_presc;
  logic                    w_tick;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_en, w_at_max;
  logic [4*NUM_DIGITS-1:0] w_q, w_q_next, r_snap;
  logic                    r_lap_valid, r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // stop outranks start even where stop itself has no effect
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else if (!stop) begin
      if (start && r_state != RUN) w_state_next = RUN;
    end else if (r_state == RUN) begin
      w_state_next = PAUSED;
    end
  end

  assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_presc <= '0;
    else if (clear)            r_presc <= '0;
    else if (r_state == RUN)   r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_comb begin
    w_en     = '0;
    w_q_next = w_q;
    w_en[0]  = w_tick;
    for (int unsigned i = 1; i < NUM_DIGITS; i++)
      w_en[i] = w_en[i-1] & w_at_max[i-1];
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (w_en[i]) w_q_next[4*i +: 4] = bcd_inc(w_q[4*i +: 4]);
  end

  assign w_wrap = w_en[NUM_DIGITS-1] & w_at_max[NUM_DIGITS-1];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .en     (w_en[g]),
      .q      (w_q[4*g +: 4]),
      .at_max (w_at_max[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_overflow <= 1'b0;
    else if (clear)   r_overflow <= 1'b0;
    else if (w_wrap)  r_overflow <= 1'b1;
  end

  // snapshot takes the post-edge value so a lap on a tick edge shows the new count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap      <= '0;
      r_lap_valid <= 1'b0;
    end else if (clear) begin
      r_snap      <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap) begin
      if (r_lap_valid) begin
        r_lap_valid <= 1'b0;
      end else if (r_state == RUN) begin
        r_snap      <= w_q_next;
        r_lap_valid <= 1'b1;
      end
    end
  end

  assign digits    = r_lap_valid ? r_snap : w_q;
  assign running   = (r_state == RUN);
  assign lap_valid = r_lap_valid;
  assign overflow  = r_overflow;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences a cascade of mod-10 (BCD decade) counters into a multi-digit stopwatch/event timer.
- Owns the start/stop/clear/lap command FSM and the tick prescaler, and generates the per-digit enables and carries.
- Drives a frozen-or-live BCD display bus.
- Sits between the user command inputs (already debounced, single-cycle pulses) and the display/readout logic.

Parameters:
- NUM_DIGITS, 4, number of cascaded BCD digits; legal range 1..8.
- PRESCALE, 10, clk cycles per count tick; legal range 1..2^16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begin or resume counting.
- stop  input  1  single-cycle pulse; pause counting.
- clear  input  1  single-cycle pulse; zero everything, return to idle.
- lap  input  1  single-cycle pulse; toggle the display freeze.
- digits  output  4*NUM_DIGITS  BCD display value; digit 0 (least significant) in [3:0].
- running  output  1  high while the FSM is in RUN.
- lap_valid  output  1  high while `digits` shows a frozen lap snapshot.
- overflow  output  1  sticky flag; set on full-scale wrap.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = IDLE; prescaler = 0; all internal digits = 0; lap snapshot = 0.
  - digits = 0, running = 0, lap_valid = 0, overflow = 0.
- FSM states: IDLE, RUN, PAUSED. All outputs are registered and reflect state the cycle after the command.
- Command priority when several arrive in the same cycle: clear > stop > start. Lap is evaluated independently but is ignored when clear is high.
- clear, from any state:
  - next state IDLE; prescaler, digits, snapshot and overflow all 0; lap_valid = 0.
- start:
  - IDLE or PAUSED -> RUN.
  - In RUN it is ignored; the prescaler is not restarted.
- stop:
  - RUN -> PAUSED; prescaler and digits hold their values.
  - In IDLE or PAUSED it is ignored.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN; holds in PAUSED; is 0 in IDLE.
  - tick = RUN && prescaler == PRESCALE-1. On tick the prescaler returns to 0.
  - With PRESCALE = 1, tick fires on every RUN cycle.
- Timing of first update:
  - start sampled at edge k -> RUN from edge k.
  - First tick is in the cycle ending at edge k+PRESCALE; digit 0 updates at that edge.
  - Resuming from PAUSED continues from the held prescaler value; no tick is lost or duplicated.
- Digit cascade:
  - enable[0] = tick.
  - enable[i] = enable[i-1] && digit[i-1] == 9.
  - An enabled digit increments 0..9, and 9 wraps to 0.
  - Digits never hold values 10..15 and never skip values.
- Full-scale wrap:
  - Occurs when all digits are 9 and tick fires. Digits become 0, overflow is set and stays set until clear or reset.
  - Counting continues.
- Lap:
  - When lap_valid = 0 and state is RUN: lap captures the current internal digits, including any update made at the same edge, into the snapshot; lap_valid = 1.
  - When lap_valid = 1, in any state: lap releases the freeze; lap_valid = 0.
  - When lap_valid = 0 and state is IDLE or PAUSED: lap is ignored.
- Display:
  - digits = snapshot while lap_valid = 1, otherwise the live internal digits.
  - Internal counting is never affected by lap.
- stop while frozen keeps the freeze. start from PAUSED keeps the freeze.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state enum: IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2.
  - BCD_MAX = 4'd9.
  - Prescaler width function: clog2 of PRESCALE, minimum 1.
- Sub-module bcd_digit:
  - Ports: clk, rst_n, clear, en, q[3:0], at_max.
  - Instantiated NUM_DIGITS times in a generate loop.
  - The top level holds the FSM, prescaler, enable chain, snapshot and output muxing.

Test Plan (NUM_DIGITS = 2, PRESCALE = 3 unless noted):
- Reset then start pulse at edge 0 -> digits = 8'h01 after edge 3, 8'h02 after edge 6; running = 1.
- Run to 8'h09, wait one more tick -> digits = 8'h10; digit 1 does not change on non-tick cycles.
- Run to 8'h99, wait one more tick -> digits = 8'h00 and overflow = 1. Overflow stays set after a further 5 ticks; clear -> overflow = 0, digits = 0, state IDLE.
- Stop 1 cycle after a tick, wait 20 cycles, start -> digits unchanged during the pause; next tick arrives exactly PRESCALE-1 cycles after the resume edge.
- Lap at 8'h12 -> digits holds 8'h12 with lap_valid = 1 while counting continues. Second lap at internal 8'h17 -> digits = 8'h17, lap_valid = 0.
- start, stop and clear in the same cycle while in RUN -> IDLE with all zeros. Separately, assert rst_n low mid-RUN with a frozen lap -> all outputs 0 immediately, without waiting for a clock edge.
